// File: rtl/id_pipe.sv
// MIPS decode stage with operand forwarding, load-use interlock and a
// valid/ready ID/EX pipeline register feeding EX.
module id_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_PORTS = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned EN_ARITH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   pc_i,
  input  logic [31:0]                   inst_i,
  output logic                          reg1_re_o,
  output logic                          reg2_re_o,
  output logic [REG_AW-1:0]             reg1_addr_o,
  output logic [REG_AW-1:0]             reg2_addr_o,
  input  logic [DATA_W-1:0]             reg1_data_i,
  input  logic [DATA_W-1:0]             reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_we_i,
  input  logic [FWD_PORTS-1:0]          fwd_pend_i,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_waddr_i,
  input  logic [FWD_PORTS*DATA_W-1:0]   fwd_wdata_i,
  input  logic                          flush_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   pc_o,
  output logic [2:0]                    alusel_o,
  output logic [7:0]                    aluop_o,
  output logic [DATA_W-1:0]             reg1_o,
  output logic [DATA_W-1:0]             reg2_o,
  output logic [REG_AW-1:0]             waddr_o,
  output logic                          we_o,
  output logic                          inst_invalid_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_ARITH = 3'b100;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_PREF    = 6'b110011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  logic [5:0]  opc;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opc   = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  logic              dec_re1;
  logic              dec_re2;
  logic [DATA_W-1:0] dec_imm1;
  logic [DATA_W-1:0] dec_imm2;
  logic [2:0]        dec_sel;
  logic [7:0]        dec_op;
  logic [REG_AW-1:0] dec_waddr;
  logic              dec_we;
  logic              dec_inv;

  // Instruction decode; anything not matched falls through as invalid.
  always_comb begin
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_imm1  = '0;
    dec_imm2  = '0;
    dec_sel   = RES_NOP;
    dec_op    = OP_NOP;
    dec_waddr = '0;
    dec_we    = 1'b0;
    dec_inv   = 1'b1;
    case (opc)
      OPC_SPECIAL: begin
        if (rs == 5'd0) begin
          case (funct)
            FN_SLL, FN_SRL, FN_SRA: begin
              dec_re2   = 1'b1;
              dec_imm1  = DATA_W'(sa);
              dec_sel   = RES_SHIFT;
              dec_op    = (funct == FN_SLL) ? OP_SLL :
                          (funct == FN_SRL) ? OP_SRL : OP_SRA;
              dec_waddr = REG_AW'(rd);
              dec_we    = 1'b1;
              dec_inv   = 1'b0;
            end
            default: ;
          endcase
        end
        if (sa == 5'd0) begin
          case (funct)
            FN_SLLV, FN_SRLV, FN_SRAV: begin
              dec_sel = RES_SHIFT;
              dec_op  = (funct == FN_SLLV) ? OP_SLL :
                        (funct == FN_SRLV) ? OP_SRL : OP_SRA;
              dec_inv = 1'b0;
            end
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              dec_sel = RES_LOGIC;
              dec_op  = (funct == FN_AND) ? OP_AND :
                        (funct == FN_OR)  ? OP_OR  :
                        (funct == FN_XOR) ? OP_XOR : OP_NOR;
              dec_inv = 1'b0;
            end
            FN_ADDU, FN_SUBU: begin
              if (EN_ARITH != 0) begin
                dec_sel = RES_ARITH;
                dec_op  = (funct == FN_ADDU) ? OP_ADDU : OP_SUBU;
                dec_inv = 1'b0;
              end
            end
            default: ;
          endcase
          if (!dec_inv && funct[5:3] != 3'b000 || funct inside {FN_SLLV, FN_SRLV, FN_SRAV}) begin
            if (!dec_inv) begin
              dec_re1   = 1'b1;
              dec_re2   = 1'b1;
              dec_waddr = REG_AW'(rd);
              dec_we    = 1'b1;
            end
          end
        end
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        dec_re1   = 1'b1;
        dec_imm2  = DATA_W'(imm);
        dec_sel   = RES_LOGIC;
        dec_op    = (opc == OPC_ANDI) ? OP_AND :
                    (opc == OPC_ORI)  ? OP_OR  : OP_XOR;
        dec_waddr = REG_AW'(rt);
        dec_we    = 1'b1;
        dec_inv   = 1'b0;
      end
      OPC_ADDIU: begin
        if (EN_ARITH != 0) begin
          dec_re1   = 1'b1;
          dec_imm2  = DATA_W'($signed(imm));
          dec_sel   = RES_ARITH;
          dec_op    = OP_ADDIU;
          dec_waddr = REG_AW'(rt);
          dec_we    = 1'b1;
          dec_inv   = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_imm2  = DATA_W'({imm, 16'h0000});
        dec_sel   = RES_LOGIC;
        dec_op    = OP_OR;
        dec_waddr = REG_AW'(rt);
        dec_we    = 1'b1;
        dec_inv   = 1'b0;
      end
      OPC_PREF: dec_inv = 1'b0;
      default: ;
    endcase
  end

  // Returns {pending, data}: $0 is hard zero, lowest-index matching port wins.
  function automatic logic [DATA_W:0] resolve(
    input logic [REG_AW-1:0]           addr,
    input logic [DATA_W-1:0]           rf,
    input logic [FWD_PORTS-1:0]        we,
    input logic [FWD_PORTS-1:0]        pend,
    input logic [FWD_PORTS*REG_AW-1:0] waddr,
    input logic [FWD_PORTS*DATA_W-1:0] wdata
  );
    logic [DATA_W:0] r;
    logic            hit;
    r   = {1'b0, rf};
    hit = 1'b0;
    if (addr == '0) begin
      r = '0;
    end else begin
      for (int unsigned k = 0; k < FWD_PORTS; k++) begin
        if (!hit && we[k] && waddr[k*REG_AW +: REG_AW] == addr) begin
          hit = 1'b1;
          r   = {pend[k], wdata[k*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  logic [DATA_W:0]   src1;
  logic [DATA_W:0]   src2;
  logic [DATA_W-1:0] opnd1;
  logic [DATA_W-1:0] opnd2;
  logic              hazard;
  logic              advance;
  logic              accept;

  assign reg1_re_o   = dec_re1;
  assign reg2_re_o   = dec_re2;
  assign reg1_addr_o = REG_AW'(rs);
  assign reg2_addr_o = REG_AW'(rt);

  assign src1  = resolve(reg1_addr_o, reg1_data_i, fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i);
  assign src2  = resolve(reg2_addr_o, reg2_data_i, fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i);
  assign opnd1 = dec_re1 ? src1[DATA_W-1:0] : dec_imm1;
  assign opnd2 = dec_re2 ? src2[DATA_W-1:0] : dec_imm2;

  assign hazard   = (dec_re1 & src1[DATA_W]) | (dec_re2 & src2[DATA_W]);
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance & (!hazard | flush_i);
  assign accept   = in_valid & in_ready & !flush_i;

  // ID/EX register: flush clears it even under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      pc_o           <= '0;
      alusel_o       <= RES_NOP;
      aluop_o        <= OP_NOP;
      reg1_o         <= '0;
      reg2_o         <= '0;
      waddr_o        <= '0;
      we_o           <= 1'b0;
      inst_invalid_o <= 1'b0;
      stall_cnt_o    <= '0;
    end else begin
      if (advance || flush_i) begin
        if (accept) begin
          out_valid      <= 1'b1;
          pc_o           <= pc_i;
          alusel_o       <= dec_sel;
          aluop_o        <= dec_op;
          reg1_o         <= opnd1;
          reg2_o         <= opnd2;
          waddr_o        <= dec_waddr;
          we_o           <= dec_we;
          inst_invalid_o <= dec_inv;
        end else begin
          out_valid      <= 1'b0;
          pc_o           <= '0;
          alusel_o       <= RES_NOP;
          aluop_o        <= OP_NOP;
          reg1_o         <= '0;
          reg2_o         <= '0;
          waddr_o        <= '0;
          we_o           <= 1'b0;
          inst_invalid_o <= 1'b0;
        end
      end
      if (in_valid && hazard && !flush_i && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
